// File: rtl/uart_rx_frame_check_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_check_if
// Bundles the configuration, strobe and status signals of the UART RX frame
// checker. CLK/RST stay as plain ports on the checker itself.
//   master : sampler/deserializer side (drives config, data, strobes, clear)
//   slave  : the frame checker (drives error flags, strobe, counters)
// Signals:
//   PAR_EN, PAR_MODE[1:0], DATA_LEN[3:0], P_DATA[DATA_WIDTH-1:0],
//   sampled_bit, par_chk_en, stp_chk_en, err_clr        (master -> slave)
//   Parity_Error, Stop_Error, frame_done, frame_err,
//   par_err_cnt, stp_err_cnt, err_sticky                (slave -> master)
// ---------------------------------------------------------------------------
interface uart_rx_frame_check_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  PAR_EN;
    logic [1:0]            PAR_MODE;
    logic [3:0]            DATA_LEN;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  sampled_bit;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  err_clr;
    logic                  Parity_Error;
    logic                  Stop_Error;
    logic                  frame_done;
    logic                  frame_err;
    logic [CNT_WIDTH-1:0]  par_err_cnt;
    logic [CNT_WIDTH-1:0]  stp_err_cnt;
    logic                  err_sticky;

    modport master (
        output PAR_EN, PAR_MODE, DATA_LEN, P_DATA, sampled_bit,
               par_chk_en, stp_chk_en, err_clr,
        input  Parity_Error, Stop_Error, frame_done, frame_err,
               par_err_cnt, stp_err_cnt, err_sticky
    );

    modport slave (
        input  PAR_EN, PAR_MODE, DATA_LEN, P_DATA, sampled_bit,
               par_chk_en, stp_chk_en, err_clr,
        output Parity_Error, Stop_Error, frame_done, frame_err,
               par_err_cnt, stp_err_cnt, err_sticky
    );
endinterface

// File: rtl/uart_rx_frame_check.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_check
// Per-frame parity and stop-bit checker for the UART receiver. A two-state
// FSM tracks whether the parity bit of the current frame has been seen; the
// stop strobe completes the frame with a one-cycle frame_done/frame_err.
// Saturating error counters and a sticky flag provide status readback.
// Ports:
//   CLK  - system clock (rising edge)
//   RST  - synchronous active-low reset
//   bus  - uart_rx_frame_check_if.slave (config, strobes, status)
// ---------------------------------------------------------------------------
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    uart_rx_frame_check_if.slave    bus
);
    localparam logic [3:0] MIN_LEN = 4'd5;
    localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH);

    typedef enum logic {IDLE, PAR_DONE} state_t;

    state_t               state_q, state_d;
    logic                 par_err_q, par_err_d;
    logic                 stp_err_q, stp_err_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0] scnt_q, scnt_d;
    logic                 sticky_q, sticky_d;

    logic [3:0] len_eff;
    logic       data_xor;
    logic       exp_par;
    logic       par_mismatch;
    logic       par_strobe;
    logic       par_eval, stp_eval;
    logic       par_fail, stp_fail;
    logic [CNT_WIDTH-1:0] pcnt_base, scnt_base;

    // Effective length clamped to [5, DATA_WIDTH]; parity over the low bits only.
    always_comb begin
        if (bus.DATA_LEN < MIN_LEN)      len_eff = MIN_LEN;
        else if (bus.DATA_LEN > MAX_LEN) len_eff = MAX_LEN;
        else                             len_eff = bus.DATA_LEN;
        data_xor = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (4'(i) < len_eff) data_xor = data_xor ^ bus.P_DATA[i];
        end
        case (bus.PAR_MODE)
            2'b00:   exp_par = data_xor;
            2'b01:   exp_par = ~data_xor;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    assign par_mismatch = bus.sampled_bit != exp_par;
    assign par_strobe   = bus.par_chk_en & bus.PAR_EN;

    always_comb begin
        state_d   = state_q;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        par_eval  = 1'b0;
        stp_eval  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.stp_chk_en) begin
                    stp_eval = 1'b1;
                    if (par_strobe) begin
                        par_eval  = 1'b1;
                        par_err_d = par_mismatch;
                    end else if (bus.PAR_EN) begin
                        // Parity bit expected but never strobed: sequence error.
                        par_eval  = 1'b1;
                        par_err_d = 1'b1;
                    end else begin
                        par_err_d = 1'b0;
                    end
                end else if (par_strobe) begin
                    par_eval  = 1'b1;
                    par_err_d = par_mismatch;
                    state_d   = PAR_DONE;
                end
            end
            PAR_DONE: begin
                if (bus.stp_chk_en) begin
                    stp_eval = 1'b1;
                    state_d  = IDLE;
                end
                // A repeated parity strobe overwrites the earlier result.
                if (par_strobe) begin
                    par_eval  = 1'b1;
                    par_err_d = par_mismatch;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stp_eval) begin
            stp_err_d = ~bus.sampled_bit;
            done_d    = 1'b1;
            ferr_d    = par_err_d | ~bus.sampled_bit;
        end
    end

    assign par_fail = par_eval & par_err_d;
    assign stp_fail = stp_eval & stp_err_d;

    // Clear is applied before the current event is counted.
    always_comb begin
        pcnt_base = bus.err_clr ? '0 : pcnt_q;
        scnt_base = bus.err_clr ? '0 : scnt_q;
        pcnt_d    = (par_fail && !(&pcnt_base)) ? pcnt_base + 1'b1 : pcnt_base;
        scnt_d    = (stp_fail && !(&scnt_base)) ? scnt_base + 1'b1 : scnt_base;
        sticky_d  = (sticky_q & ~bus.err_clr) | par_fail | stp_fail;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= IDLE;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            pcnt_q    <= '0;
            scnt_q    <= '0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            pcnt_q    <= pcnt_d;
            scnt_q    <= scnt_d;
            sticky_q  <= sticky_d;
        end
    end

    assign bus.Parity_Error = par_err_q;
    assign bus.Stop_Error   = stp_err_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_err    = ferr_q;
    assign bus.par_err_cnt  = pcnt_q;
    assign bus.stp_err_cnt  = scnt_q;
    assign bus.err_sticky   = sticky_q;
endmodule
